// File: rtl/cpu_dma_rx_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_dma_rx_queue_if
// Description : Bus bundle for the host-to-datapath CPU rx queue. It carries
//               the 32-bit DMA write side and the 64-bit datapath output side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_dma_rx_queue_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter int DMA_DATA_WIDTH = 32,
  parameter int DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8
);
  logic                      cpu_q_dma_wr;
  logic [DMA_DATA_WIDTH-1:0] cpu_q_dma_wr_data;
  logic [DMA_CTRL_WIDTH-1:0] cpu_q_dma_wr_ctrl;
  logic                      cpu_q_dma_nearly_full;
  logic                      cpu_q_dma_can_wr_pkt;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [CTRL_WIDTH-1:0]     out_ctrl;
  logic                      out_wr;
  logic                      out_rdy;

  // Host / downstream side: issues DMA writes and consumes datapath words
  modport master (
    output cpu_q_dma_wr, cpu_q_dma_wr_data, cpu_q_dma_wr_ctrl, out_rdy,
    input  cpu_q_dma_nearly_full, cpu_q_dma_can_wr_pkt, out_data, out_ctrl, out_wr
  );

  // Queue side
  modport slave (
    input  cpu_q_dma_wr, cpu_q_dma_wr_data, cpu_q_dma_wr_ctrl, out_rdy,
    output cpu_q_dma_nearly_full, cpu_q_dma_can_wr_pkt, out_data, out_ctrl, out_wr
  );
endinterface
`default_nettype wire

// File: rtl/cpu_dma_rx_queue.sv
`default_nettype none
// ============================================================================
// Module      : cpu_dma_rx_queue
// Description : Buffers whole packets written by the host DMA engine as 32-bit
//               little-endian words, repacks them into 64-bit big-endian
//               datapath words and releases each packet, prefixed with a
//               module header, only once it has been completely written.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_dma_rx_queue #(
  parameter int          DATA_WIDTH           = 64,
  parameter int          CTRL_WIDTH           = DATA_WIDTH / 8,
  parameter int          DMA_DATA_WIDTH       = 32,
  parameter int          DMA_CTRL_WIDTH       = DMA_DATA_WIDTH / 8,
  parameter logic [7:0]  STAGE_NUMBER         = 8'hff,
  parameter logic [15:0] SRC_PORT             = 16'h0001,
  parameter int          DATA_FIFO_DEPTH_BITS = 9,
  parameter int          LEN_FIFO_DEPTH_BITS  = 3
) (
  input  wire logic          clk,
  input  wire logic          reset,
  cpu_dma_rx_queue_if.slave  bus,
  input  wire logic          rx_queue_en,
  output logic               rx_pkt_stored,
  output logic               rx_pkt_removed,
  output logic               rx_pkt_dropped,
  output logic               rx_q_overrun,
  output logic [11:0]        rx_pkt_byte_cnt,
  output logic [9:0]         rx_pkt_word_cnt
);

  localparam int AW  = DATA_FIFO_DEPTH_BITS;
  localparam int LAW = LEN_FIFO_DEPTH_BITS;
  localparam int EW  = DATA_WIDTH + CTRL_WIDTH;

  localparam logic [AW:0]  DEPTH_L         = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]  NEARLY_FULL_MIN = (AW+1)'(2);
  localparam logic [AW:0]  PKT_FREE_MIN    = (AW+1)'(257);
  localparam logic [LAW:0] LEN_DEPTH_L     = {1'b1, {LAW{1'b0}}};
  localparam logic [11:0]  MAX_PKT_BYTES   = 12'd2048;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;

  // Storage: data entries are {ctrl, data}; length entries are {words, bytes}
  logic [EW-1:0] data_mem [0:(1<<AW)-1];
  logic [21:0]   len_mem  [0:(1<<LAW)-1];

  // Data FIFO pointers: wr_ptr runs ahead speculatively, commit_ptr marks
  // the end of the last complete packet, rd_ptr is the output side.
  logic [AW:0]  wr_ptr, commit_ptr, rd_ptr;
  logic [AW:0]  data_used, data_free;
  logic         data_full;
  logic [LAW:0] len_wr_ptr, len_rd_ptr, len_used;
  logic         len_full, len_empty, len_full_eff;

  // DMA assembly state
  logic                      phase;
  logic                      dropping;
  logic [DMA_DATA_WIDTH-1:0] hold;
  logic [11:0]               byte_cnt;
  logic                      push_pending;
  logic [9:0]                push_words;
  logic [11:0]               push_bytes;

  // Output side state
  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [CTRL_WIDTH-1:0] out_ctrl_reg;
  logic                  out_wr_reg;

  // Decoded current DMA word
  logic                      last_word;
  logic [2:0]                valid_bytes;
  logic [DMA_DATA_WIDTH-1:0] swapped;
  logic [11:0]               total_bytes;
  logic                      oversize;
  logic [3:0]                bytes64;
  logic [CTRL_WIDTH-1:0]     last_ctrl;
  logic                      write_slot;
  logic                      pkt_error;
  logic [EW-1:0]             fifo_wentry;
  logic                      fifo_we;
  logic [EW-1:0]             rd_entry;
  logic [21:0]               len_head;
  logic [DATA_WIDTH-1:0]     header;
  logic                      has_word;

  // Occupancy and flow-control flags derived from the pointers
  always_comb begin
    data_used    = wr_ptr - rd_ptr;
    data_free    = DEPTH_L - data_used;
    data_full    = (data_used == DEPTH_L);
    len_used     = len_wr_ptr - len_rd_ptr;
    len_full     = (len_used == LEN_DEPTH_L);
    len_empty    = (len_used == '0);
    // A push still in flight already owns a length slot
    len_full_eff = len_full || (push_pending && (len_used == LEN_DEPTH_L - 1'b1));
  end

  assign bus.cpu_q_dma_nearly_full = (data_free < NEARLY_FULL_MIN);
  assign bus.cpu_q_dma_can_wr_pkt  = (data_free >= PKT_FREE_MIN) && !len_full;

  // Decode lane count, mask invalid lanes and byte-swap the incoming DMA word
  always_comb begin
    last_word   = |bus.cpu_q_dma_wr_ctrl;
    valid_bytes = 3'(DMA_CTRL_WIDTH);
    for (int i = 0; i < DMA_CTRL_WIDTH; i++)
      if (bus.cpu_q_dma_wr_ctrl[i]) valid_bytes = 3'(i + 1);
    swapped = '0;
    for (int i = 0; i < DMA_CTRL_WIDTH; i++)
      if (i < int'(valid_bytes))
        swapped[(DMA_CTRL_WIDTH-1-i)*8 +: 8] = bus.cpu_q_dma_wr_data[i*8 +: 8];
  end

  // Word/packet bookkeeping for the DMA word currently presented
  always_comb begin
    total_bytes = byte_cnt + 12'(valid_bytes);
    oversize    = (total_bytes > MAX_PKT_BYTES);
    bytes64     = phase ? (4'd4 + 4'(valid_bytes)) : 4'(valid_bytes);
    last_ctrl   = {1'b1, {(CTRL_WIDTH-1){1'b0}}} >> (bytes64 - 4'd1);
    write_slot  = phase || last_word;
    pkt_error   = bus.cpu_q_dma_wr && !dropping &&
                  (data_full || oversize || (last_word && len_full_eff));
    fifo_we     = bus.cpu_q_dma_wr && !dropping && !pkt_error && write_slot;
    fifo_wentry = {(last_word ? last_ctrl : {CTRL_WIDTH{1'b0}}),
                   (phase ? {hold, swapped} : {swapped, {DMA_DATA_WIDTH{1'b0}}})};
  end

  // Data FIFO storage write
  always_ff @(posedge clk) begin
    if (fifo_we) data_mem[wr_ptr[AW-1:0]] <= fifo_wentry;
  end

  // DMA assembly: speculative write, commit on a clean last word, rewind on error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      commit_ptr     <= '0;
      phase          <= 1'b0;
      dropping       <= 1'b0;
      hold           <= '0;
      byte_cnt       <= '0;
      push_pending   <= 1'b0;
      push_words     <= '0;
      push_bytes     <= '0;
      rx_q_overrun   <= 1'b0;
      rx_pkt_dropped <= 1'b0;
    end else begin
      rx_q_overrun   <= bus.cpu_q_dma_wr && data_full;
      rx_pkt_dropped <= 1'b0;
      push_pending   <= 1'b0;
      if (bus.cpu_q_dma_wr) begin
        if (dropping || pkt_error) begin
          if (pkt_error) wr_ptr <= commit_ptr;
          if (last_word) begin
            dropping       <= 1'b0;
            phase          <= 1'b0;
            byte_cnt       <= '0;
            rx_pkt_dropped <= 1'b1;
          end else begin
            dropping <= 1'b1;
          end
        end else begin
          if (write_slot) wr_ptr <= wr_ptr + 1'b1;
          if (!phase) hold <= swapped;
          if (last_word) begin
            // The last word always occupies a slot, so the packet ends at wr_ptr+1
            commit_ptr   <= wr_ptr + 1'b1;
            push_pending <= 1'b1;
            push_words   <= 10'((total_bytes + 12'd7) >> 3);
            push_bytes   <= total_bytes;
            phase        <= 1'b0;
            byte_cnt     <= '0;
          end else begin
            phase    <= ~phase;
            byte_cnt <= total_bytes;
          end
        end
      end
    end
  end

  // Length FIFO storage write
  always_ff @(posedge clk) begin
    if (push_pending) len_mem[len_wr_ptr[LAW-1:0]] <= {push_words, push_bytes};
  end

  // Length FIFO push side and committed-packet statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_wr_ptr      <= '0;
      rx_pkt_stored   <= 1'b0;
      rx_pkt_byte_cnt <= '0;
      rx_pkt_word_cnt <= '0;
    end else begin
      rx_pkt_stored <= push_pending;
      if (push_pending) begin
        len_wr_ptr      <= len_wr_ptr + 1'b1;
        rx_pkt_byte_cnt <= push_bytes;
        rx_pkt_word_cnt <= push_words;
      end
    end
  end

  // Head-of-queue views for the output side
  always_comb begin
    rd_entry = data_mem[rd_ptr[AW-1:0]];
    len_head = len_mem[len_rd_ptr[LAW-1:0]];
    header   = {16'h0000, 6'd0, len_head[21:12], SRC_PORT, 4'd0, len_head[11:0]};
    has_word = (rd_ptr != commit_ptr);
  end

  // Output FSM: header then body, one registered word per sampled out_rdy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      rd_ptr         <= '0;
      len_rd_ptr     <= '0;
      out_data_reg   <= '0;
      out_ctrl_reg   <= '0;
      out_wr_reg     <= 1'b0;
      rx_pkt_removed <= 1'b0;
    end else begin
      out_wr_reg     <= 1'b0;
      rx_pkt_removed <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!len_empty && rx_queue_en) state <= S_HDR;
        end
        S_HDR: begin
          if (bus.out_rdy) begin
            out_wr_reg   <= 1'b1;
            out_data_reg <= header;
            out_ctrl_reg <= STAGE_NUMBER;
            state        <= S_BODY;
          end
        end
        S_BODY: begin
          if (bus.out_rdy && has_word) begin
            out_wr_reg   <= 1'b1;
            out_data_reg <= rd_entry[DATA_WIDTH-1:0];
            out_ctrl_reg <= rd_entry[EW-1:DATA_WIDTH];
            rd_ptr       <= rd_ptr + 1'b1;
            if (|rd_entry[EW-1:DATA_WIDTH]) begin
              len_rd_ptr     <= len_rd_ptr + 1'b1;
              rx_pkt_removed <= 1'b1;
              state          <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_data = out_data_reg;
  assign bus.out_ctrl = out_ctrl_reg;
  assign bus.out_wr   = out_wr_reg;

endmodule
`default_nettype wire

// File: tb/tb_cpu_dma_rx_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_dma_rx_queue
// Description : Scoreboard bench for cpu_dma_rx_queue. Stimulus pushes the
//               expected datapath words; a monitor pops them on out_wr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_dma_rx_queue;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_queue_en;
  logic        rx_pkt_stored, rx_pkt_removed, rx_pkt_dropped, rx_q_overrun;
  logic [11:0] rx_pkt_byte_cnt;
  logic [9:0]  rx_pkt_word_cnt;

  cpu_dma_rx_queue_if bus ();

  cpu_dma_rx_queue dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .rx_queue_en     (rx_queue_en),
    .rx_pkt_stored   (rx_pkt_stored),
    .rx_pkt_removed  (rx_pkt_removed),
    .rx_pkt_dropped  (rx_pkt_dropped),
    .rx_q_overrun    (rx_q_overrun),
    .rx_pkt_byte_cnt (rx_pkt_byte_cnt),
    .rx_pkt_word_cnt (rx_pkt_word_cnt)
  );

  always #5 clk = ~clk;

  beat_t       exp_q[$];
  logic [21:0] exp_len_q[$];
  int tests = 0, fails = 0;
  int stored_cnt = 0, removed_cnt = 0, dropped_cnt = 0, overrun_cnt = 0;
  int exp_stored = 0, exp_removed = 0, exp_dropped = 0, exp_overrun = 0;
  int out_wr_count = 0;
  int rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pbyte(input int seed, input int i);
    return 8'(seed * 37 + i * 13 + (i >> 5) + 1);
  endfunction

  task automatic dma_word(input logic [31:0] d, input logic [3:0] c);
    bus.cpu_q_dma_wr      = 1'b1;
    bus.cpu_q_dma_wr_data = d;
    bus.cpu_q_dma_wr_ctrl = c;
    tick();
    bus.cpu_q_dma_wr      = 1'b0;
    bus.cpu_q_dma_wr_ctrl = 4'h0;
  endtask

  // Send one packet; when ok, queue the header and big-endian body words
  task automatic send_pkt(input int nbytes, input int seed, input logic [3:0] extra, input bit ok);
    int nw, w64, nv, v;
    logic [63:0] d64;
    logic [31:0] d32;
    logic [7:0]  c8;
    logic [3:0]  top, c4;
    nw  = (nbytes + 3) / 4;
    w64 = (nbytes + 7) / 8;
    if (ok) begin
      exp_len_q.push_back({10'(w64), 12'(nbytes)});
      exp_q.push_back('{data: {16'h0000, 16'(w64), 16'h0001, 16'(nbytes)}, ctrl: 8'hff});
      for (int w = 0; w < w64; w++) begin
        nv  = nbytes - 8 * w;
        if (nv > 8) nv = 8;
        d64 = '0;
        for (int k = 0; k < nv; k++) d64[63 - 8*k -: 8] = pbyte(seed, 8*w + k);
        c8  = 8'h00;
        if (w == w64 - 1) c8 = 8'h80 >> (nv - 1);
        exp_q.push_back('{data: d64, ctrl: c8});
      end
      exp_stored++;
      exp_removed++;
    end else begin
      exp_dropped++;
    end
    for (int j = 0; j < nw; j++) begin
      v = nbytes - 4 * j;
      if (v > 4) v = 4;
      for (int k = 0; k < 4; k++)
        d32[8*k +: 8] = (k < v) ? pbyte(seed, 4*j + k) : (8'hA5 ^ 8'(k));
      c4 = 4'h0;
      if (j == nw - 1) begin
        top = 4'b0001 << (v - 1);
        c4  = top | (extra & (top - 4'd1));
      end
      dma_word(d32, c4);
    end
  endtask

  // Wait for the scoreboard to drain, then compare event counts and clear them
  task automatic checkpoint(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check({name, "_drain"},   64'(exp_q.size()),     64'd0);
    check({name, "_lenq"},    64'(exp_len_q.size()), 64'd0);
    check({name, "_stored"},  64'(stored_cnt),  64'(exp_stored));
    check({name, "_removed"}, 64'(removed_cnt), 64'(exp_removed));
    check({name, "_dropped"}, 64'(dropped_cnt), 64'(exp_dropped));
    check({name, "_overrun"}, 64'(overrun_cnt), 64'(exp_overrun));
    stored_cnt = 0; removed_cnt = 0; dropped_cnt = 0; overrun_cnt = 0;
    exp_stored = 0; exp_removed = 0; exp_dropped = 0; exp_overrun = 0;
  endtask

  // Monitor: compare every emitted word and count status pulses
  initial begin
    beat_t       e;
    logic [21:0] l;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.out_wr) begin
          out_wr_count++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: out_data %h out_ctrl %h with empty scoreboard",
                     bus.out_data, bus.out_ctrl);
          end else begin
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_ctrl", 64'(bus.out_ctrl), 64'(e.ctrl));
          end
        end
        if (rx_pkt_stored) begin
          stored_cnt++;
          if (exp_len_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_store: byte_cnt %0d word_cnt %0d", rx_pkt_byte_cnt, rx_pkt_word_cnt);
          end else begin
            l = exp_len_q.pop_front();
            check("stored_byte_cnt", 64'(rx_pkt_byte_cnt), 64'(l[11:0]));
            check("stored_word_cnt", 64'(rx_pkt_word_cnt), 64'(l[21:12]));
          end
        end
        if (rx_pkt_removed) removed_cnt++;
        if (rx_pkt_dropped) dropped_cnt++;
        if (rx_q_overrun)   overrun_cnt++;
      end
    end
  end

  // Downstream ready pattern: 0 = always ready, 1 = toggling, 2 = random
  initial begin
    bus.out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.out_rdy = ~bus.out_rdy;
        2:       bus.out_rdy = 1'($urandom_range(0, 1));
        default: bus.out_rdy = 1'b1;
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, %0d words still expected", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    reset                 = 1'b1;
    rx_queue_en           = 1'b0;
    bus.cpu_q_dma_wr      = 1'b0;
    bus.cpu_q_dma_wr_data = '0;
    bus.cpu_q_dma_wr_ctrl = '0;
    #1 reset = 1'b0;
    #2;
    check("rst_out_wr",      64'(bus.out_wr),                64'd0);
    check("rst_out_data",    bus.out_data,                   64'd0);
    check("rst_nearly_full", 64'(bus.cpu_q_dma_nearly_full), 64'd0);
    check("rst_can_wr_pkt",  64'(bus.cpu_q_dma_can_wr_pkt),  64'd1);
    check("rst_byte_cnt",    64'(rx_pkt_byte_cnt),           64'd0);
    #9 reset = 1'b1;
    repeat (3) tick();

    // Single packets, always ready
    rx_queue_en = 1'b1;
    send_pkt(60, 1, 4'h0, 1'b1);
    checkpoint("pkt60");
    send_pkt(61, 2, 4'h0, 1'b1);
    checkpoint("pkt61");

    // Back-to-back packets of every tail length with toggling ready
    rdy_mode = 1;
    send_pkt(1, 3, 4'hF, 1'b1);
    send_pkt(6, 4, 4'hF, 1'b1);
    send_pkt(7, 5, 4'hF, 1'b1);
    send_pkt(8, 6, 4'h0, 1'b1);
    send_pkt(9, 7, 4'h0, 1'b1);
    send_pkt(14, 8, 4'h1, 1'b1);
    send_pkt(31, 9, 4'h3, 1'b1);
    send_pkt(64, 10, 4'h7, 1'b1);
    send_pkt(100, 11, 4'h0, 1'b1);
    checkpoint("b2b");

    // Largest legal packet, then one byte over the limit
    rdy_mode = 2;
    send_pkt(2048, 12, 4'h0, 1'b1);
    checkpoint("max");
    send_pkt(2049, 13, 4'h0, 1'b0);
    send_pkt(3, 14, 4'h0, 1'b1);
    checkpoint("oversize");

    // Length FIFO full: the ninth packet is dropped
    rdy_mode    = 0;
    rx_queue_en = 1'b0;
    for (int p = 0; p < 8; p++) send_pkt(10, 20 + p, 4'h0, 1'b1);
    repeat (2) tick();
    check("lenfull_can_wr_pkt", 64'(bus.cpu_q_dma_can_wr_pkt), 64'd0);
    send_pkt(10, 28, 4'h0, 1'b0);
    base = out_wr_count;
    repeat (20) tick();
    check("disabled_no_output", 64'(out_wr_count), 64'(base));
    rx_queue_en = 1'b1;
    checkpoint("lenfull");

    // Data FIFO overrun with two committed packets held back
    rx_queue_en = 1'b0;
    send_pkt(2000, 30, 4'h0, 1'b1);
    tick();
    check("free262_can_wr_pkt", 64'(bus.cpu_q_dma_can_wr_pkt), 64'd1);
    send_pkt(2000, 31, 4'h0, 1'b1);
    tick();
    check("free12_can_wr_pkt",  64'(bus.cpu_q_dma_can_wr_pkt),  64'd0);
    check("free12_nearly_full", 64'(bus.cpu_q_dma_nearly_full), 64'd0);
    for (int j = 0; j < 28; j++) begin
      dma_word(32'hC0DE_0000 + 32'(j), (j == 27) ? 4'b1000 : 4'b0000);
      if (j == 19) check("free2_nearly_full", 64'(bus.cpu_q_dma_nearly_full), 64'd0);
      if (j == 21) check("free1_nearly_full", 64'(bus.cpu_q_dma_nearly_full), 64'd1);
      if (j == 23) check("full_can_wr_pkt",   64'(bus.cpu_q_dma_can_wr_pkt),  64'd0);
    end
    exp_dropped++;
    exp_overrun++;
    send_pkt(16, 32, 4'h0, 1'b1);
    // Enable, then disable mid-body: first packet completes, next stays held
    base = out_wr_count;
    rx_queue_en = 1'b1;
    n = 0;
    while (out_wr_count < base + 3 && n < 100) begin
      tick();
      n++;
    end
    rx_queue_en = 1'b0;
    repeat (300) tick();
    check("en_low_mid_body", 64'(out_wr_count - base), 64'd251);
    rx_queue_en = 1'b1;
    checkpoint("overrun");

    // Asynchronous reset with a packet leaving and another arriving
    rdy_mode = 1;
    send_pkt(200, 40, 4'h0, 1'b1);
    for (int j = 0; j < 5; j++) dma_word(32'h1234_5600 + 32'(j), 4'h0);
    #2 reset = 1'b0;
    #1;
    check("arst_out_wr",      64'(bus.out_wr),                64'd0);
    check("arst_out_data",    bus.out_data,                   64'd0);
    check("arst_out_ctrl",    64'(bus.out_ctrl),              64'd0);
    check("arst_can_wr_pkt",  64'(bus.cpu_q_dma_can_wr_pkt),  64'd1);
    check("arst_nearly_full", 64'(bus.cpu_q_dma_nearly_full), 64'd0);
    check("arst_byte_cnt",    64'(rx_pkt_byte_cnt),           64'd0);
    exp_q.delete();
    exp_len_q.delete();
    stored_cnt = 0; removed_cnt = 0; dropped_cnt = 0; overrun_cnt = 0;
    exp_stored = 0; exp_removed = 0; exp_dropped = 0; exp_overrun = 0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    send_pkt(24, 41, 4'h0, 1'b1);
    checkpoint("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
